// File: rtl/rtc_pkg.sv
// rtc_pkg: shared calendar definitions for the real-time clock.
//   MON_*          month numbers (1-based)
//   is_leap        Gregorian leap-year test on a full year number
//   days_in_month  month length in days for a given month and leap flag
package rtc_pkg;

  localparam logic [3:0] MON_JAN = 4'd1;
  localparam logic [3:0] MON_FEB = 4'd2;
  localparam logic [3:0] MON_MAR = 4'd3;
  localparam logic [3:0] MON_APR = 4'd4;
  localparam logic [3:0] MON_MAY = 4'd5;
  localparam logic [3:0] MON_JUN = 4'd6;
  localparam logic [3:0] MON_JUL = 4'd7;
  localparam logic [3:0] MON_AUG = 4'd8;
  localparam logic [3:0] MON_SEP = 4'd9;
  localparam logic [3:0] MON_OCT = 4'd10;
  localparam logic [3:0] MON_NOV = 4'd11;
  localparam logic [3:0] MON_DEC = 4'd12;

  // Divisible by 4 but not by 100, or divisible by 400.
  function automatic logic is_leap(input int unsigned year);
    return (((year % 32'd4) == 32'd0) && ((year % 32'd100) != 32'd0)) ||
           ((year % 32'd400) == 32'd0);
  endfunction

  // Out-of-range months return 0 so that any day fails a range check against it.
  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
    logic [4:0] dim;
    case (month)
      MON_JAN, MON_MAR, MON_MAY, MON_JUL,
      MON_AUG, MON_OCT, MON_DEC:          dim = 5'd31;
      MON_APR, MON_JUN, MON_SEP, MON_NOV: dim = 5'd30;
      MON_FEB:                            dim = leap ? 5'd29 : 5'd28;
      default:                            dim = 5'd0;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: divides count-enabled CLK cycles down to a one-per-second tick.
//   CLK, RST  clock, asynchronous active-high reset
//   ce_i      count enable; the counter holds while low
//   clr_i     synchronous clear to 0 (wins over ce_i)
//   tick_o    combinational, high on the enabled cycle where the counter wraps
module rtc_prescaler #(
  parameter int unsigned PRESCALE = 50_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic ce_i,
  input  logic clr_i,
  output logic tick_o
);
  import rtc_pkg::*;

  // A one-bit counter is kept for PRESCALE=1; it simply stays at 0 and ticks every enable.
  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count and wrap tick.
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ce_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_calendar.sv
// rtc_calendar: hh:mm:ss plus day/month/year real-time clock with Gregorian leap years.
//   CLK, RST               clock, asynchronous active-high reset
//   CE                     count enable for the seconds prescaler
//   LOAD, L_*              one-cycle load strobe and the time/date to load (range checked)
//   ALARM_EN, A_HOURS/MINS hh:mm alarm
//   Hours..Year            current time and date (Year is an offset from YEAR_BASE)
//   Hours12, PM            12-hour display decode of Hours
//   SEC_PULSE              one cycle high alongside every new seconds value
//   ALARM                  one cycle high when a tick reaches A_HOURS:A_MINS:00
//   LOAD_ERR               one cycle high after a rejected load
module rtc_calendar #(
  parameter int unsigned PRESCALE  = 50_000_000,
  parameter int unsigned YEAR_BASE = 2000,
  parameter int unsigned YEAR_W    = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE,
  input  logic              LOAD,
  input  logic [4:0]        L_HOURS,
  input  logic [5:0]        L_MINS,
  input  logic [5:0]        L_SECS,
  input  logic [4:0]        L_DAY,
  input  logic [3:0]        L_MONTH,
  input  logic [YEAR_W-1:0] L_YEAR,
  input  logic              ALARM_EN,
  input  logic [4:0]        A_HOURS,
  input  logic [5:0]        A_MINS,
  output logic [4:0]        Hours,
  output logic [5:0]        Mins,
  output logic [5:0]        Secs,
  output logic [4:0]        Day,
  output logic [3:0]        Month,
  output logic [YEAR_W-1:0] Year,
  output logic [3:0]        Hours12,
  output logic              PM,
  output logic              SEC_PULSE,
  output logic              ALARM,
  output logic              LOAD_ERR
);
  import rtc_pkg::*;

  logic [4:0]        hours_q, hours_d;
  logic [5:0]        mins_q, mins_d;
  logic [5:0]        secs_q, secs_d;
  logic [4:0]        day_q, day_d;
  logic [3:0]        month_q, month_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic              sec_pulse_q, sec_pulse_d;
  logic              alarm_q, alarm_d;
  logic              load_err_q, load_err_d;

  logic       tick_s;
  logic       load_ok_s;
  logic [4:0] load_dim_s;
  logic [4:0] cur_dim_s;

  // A load (valid or not) suppresses counting for that cycle; only a valid load clears.
  rtc_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .CLK    (CLK),
    .RST    (RST),
    .ce_i   (CE & ~LOAD),
    .clr_i  (LOAD & load_ok_s),
    .tick_o (tick_s)
  );

  assign load_dim_s = days_in_month(L_MONTH, is_leap(YEAR_BASE + 32'(L_YEAR)));
  assign cur_dim_s  = days_in_month(month_q, is_leap(YEAR_BASE + 32'(year_q)));

  // load_dim_s is 0 for an illegal month, so the day check also rejects it.
  assign load_ok_s = (L_HOURS < 5'd24) && (L_MINS < 6'd60) && (L_SECS < 6'd60) &&
                     (L_DAY >= 5'd1) && (L_DAY <= load_dim_s);

  // Next-state: load has priority over the seconds tick, then the carry chain.
  always_comb begin
    hours_d     = hours_q;
    mins_d      = mins_q;
    secs_d      = secs_q;
    day_d       = day_q;
    month_d     = month_q;
    year_d      = year_q;
    sec_pulse_d = 1'b0;
    alarm_d     = 1'b0;
    load_err_d  = 1'b0;
    if (LOAD) begin
      if (load_ok_s) begin
        hours_d = L_HOURS;
        mins_d  = L_MINS;
        secs_d  = L_SECS;
        day_d   = L_DAY;
        month_d = L_MONTH;
        year_d  = L_YEAR;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick_s) begin
      sec_pulse_d = 1'b1;
      if (secs_q == 6'd59) begin
        secs_d = 6'd0;
        if (mins_q == 6'd59) begin
          mins_d = 6'd0;
          if (hours_q == 5'd23) begin
            hours_d = 5'd0;
            if (day_q >= cur_dim_s) begin
              day_d = 5'd1;
              if (month_q == MON_DEC) begin
                month_d = MON_JAN;
                year_d  = year_q + YEAR_W'(1);
              end else begin
                month_d = month_q + 4'd1;
              end
            end else begin
              day_d = day_q + 5'd1;
            end
          end else begin
            hours_d = hours_q + 5'd1;
          end
        end else begin
          mins_d = mins_q + 6'd1;
        end
      end else begin
        secs_d = secs_q + 6'd1;
      end
      // Next time is always in range, so out-of-range alarm settings never match.
      alarm_d = ALARM_EN && (hours_d == A_HOURS) && (mins_d == A_MINS) && (secs_d == 6'd0);
    end else begin
      sec_pulse_d = 1'b0;
    end
  end

  // Time/date and pulse registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hours_q     <= 5'd0;
      mins_q      <= 6'd0;
      secs_q      <= 6'd0;
      day_q       <= 5'd1;
      month_q     <= MON_JAN;
      year_q      <= '0;
      sec_pulse_q <= 1'b0;
      alarm_q     <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      hours_q     <= hours_d;
      mins_q      <= mins_d;
      secs_q      <= secs_d;
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      sec_pulse_q <= sec_pulse_d;
      alarm_q     <= alarm_d;
      load_err_q  <= load_err_d;
    end
  end

  // 12-hour decode: 0 -> 12 AM, 13..23 -> 1..11 PM.
  always_comb begin
    Hours12 = hours_q[3:0];
    if (hours_q == 5'd0) begin
      Hours12 = 4'd12;
    end else if (hours_q > 5'd12) begin
      Hours12 = 4'(hours_q - 5'd12);
    end else begin
      Hours12 = hours_q[3:0];
    end
  end

  assign PM        = (hours_q >= 5'd12);
  assign Hours     = hours_q;
  assign Mins      = mins_q;
  assign Secs      = secs_q;
  assign Day       = day_q;
  assign Month     = month_q;
  assign Year      = year_q;
  assign SEC_PULSE = sec_pulse_q;
  assign ALARM     = alarm_q;
  assign LOAD_ERR  = load_err_q;

endmodule

// File: tb/tb_rtc_calendar.sv
// tb_rtc_calendar: directed and randomized checks of rtc_calendar against a
// seconds-of-day calendar model.
module tb_rtc_calendar;

  localparam int PS = 4;

  logic       CLK = 1'b0;
  logic       RST, CE, LOAD, ALARM_EN;
  logic [4:0] L_HOURS, L_DAY, A_HOURS;
  logic [5:0] L_MINS, L_SECS, A_MINS;
  logic [3:0] L_MONTH;
  logic [6:0] L_YEAR;
  logic [4:0] Hours, Day;
  logic [5:0] Mins, Secs;
  logic [3:0] Month, Hours12;
  logic [6:0] Year;
  logic       PM, SEC_PULSE, ALARM, LOAD_ERR;

  rtc_calendar #(.PRESCALE(PS), .YEAR_BASE(2000), .YEAR_W(7)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .LOAD(LOAD),
    .L_HOURS(L_HOURS), .L_MINS(L_MINS), .L_SECS(L_SECS), .L_DAY(L_DAY),
    .L_MONTH(L_MONTH), .L_YEAR(L_YEAR), .ALARM_EN(ALARM_EN),
    .A_HOURS(A_HOURS), .A_MINS(A_MINS),
    .Hours(Hours), .Mins(Mins), .Secs(Secs), .Day(Day), .Month(Month), .Year(Year),
    .Hours12(Hours12), .PM(PM), .SEC_PULSE(SEC_PULSE), .ALARM(ALARM), .LOAD_ERR(LOAD_ERR)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int al_cnt = 0;
  int sp_cnt = 0;

  // Reference model: time of day as seconds since midnight plus the date.
  int m_sod, m_day, m_month, m_year, m_pre;
  bit e_sp, e_al, e_err;

  function automatic int mlen(input int mo, input int yr);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int y;
    y = 2000 + yr;
    if (mo == 2 && (((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0))) return 29;
    return t[mo - 1];
  endfunction

  task automatic m_reset();
    m_sod = 0; m_day = 1; m_month = 1; m_year = 0; m_pre = 0;
    e_sp = 1'b0; e_al = 1'b0; e_err = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit ok;
    if (RST) begin
      m_reset();
    end else begin
      e_sp = 1'b0; e_al = 1'b0; e_err = 1'b0;
      if (LOAD) begin
        ok = (L_HOURS < 24) && (L_MINS < 60) && (L_SECS < 60) && (L_MONTH >= 1) && (L_MONTH <= 12);
        if (ok) ok = (L_DAY >= 1) && (int'(L_DAY) <= mlen(int'(L_MONTH), int'(L_YEAR)));
        if (ok) begin
          m_sod = int'(L_HOURS) * 3600 + int'(L_MINS) * 60 + int'(L_SECS);
          m_day = int'(L_DAY); m_month = int'(L_MONTH); m_year = int'(L_YEAR); m_pre = 0;
        end else begin
          e_err = 1'b1;
        end
      end else if (CE) begin
        if (m_pre == PS - 1) begin
          m_pre = 0;
          e_sp = 1'b1;
          m_sod = m_sod + 1;
          if (m_sod == 86400) begin
            m_sod = 0;
            m_day = m_day + 1;
            if (m_day > mlen(m_month, m_year)) begin
              m_day = 1;
              m_month = m_month + 1;
              if (m_month > 12) begin
                m_month = 1;
                m_year = (m_year + 1) % 128;
              end
            end
          end
          if (ALARM_EN && A_HOURS < 24 && A_MINS < 60 &&
              m_sod == int'(A_HOURS) * 3600 + int'(A_MINS) * 60) e_al = 1'b1;
        end else begin
          m_pre = m_pre + 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int h, h12;
    h = m_sod / 3600;
    h12 = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
    chk("hours", 32'(Hours), 32'(h));
    chk("mins", 32'(Mins), 32'((m_sod / 60) % 60));
    chk("secs", 32'(Secs), 32'(m_sod % 60));
    chk("day", 32'(Day), 32'(m_day));
    chk("month", 32'(Month), 32'(m_month));
    chk("year", 32'(Year), 32'(m_year));
    chk("hours12", 32'(Hours12), 32'(h12));
    chk("pm", 32'(PM), 32'(h >= 12));
    chk("sec_pulse", 32'(SEC_PULSE), 32'(e_sp));
    chk("alarm", 32'(ALARM), 32'(e_al));
    chk("load_err", 32'(LOAD_ERR), 32'(e_err));
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    if (ALARM === 1'b1) al_cnt++;
    if (SEC_PULSE === 1'b1) sp_cnt++;
    check_all();
  endtask

  task automatic do_load(input int h, input int mi, input int s, input int d, input int mo, input int y);
    L_HOURS = 5'(h); L_MINS = 6'(mi); L_SECS = 6'(s);
    L_DAY = 5'(d); L_MONTH = 4'(mo); L_YEAR = 7'(y);
    LOAD = 1'b1;
    step();
    LOAD = 1'b0;
  endtask

  int ylist[5] = '{0, 24, 99, 100, 127};

  initial begin
    RST = 1'b1; CE = 1'b0; LOAD = 1'b0; ALARM_EN = 1'b0;
    L_HOURS = 5'd0; L_MINS = 6'd0; L_SECS = 6'd0; L_DAY = 5'd1; L_MONTH = 4'd1; L_YEAR = 7'd0;
    A_HOURS = 5'd0; A_MINS = 6'd0;
    m_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    chk("reset_day", 32'(Day), 32'd1);
    RST = 1'b0;

    // Year rollover from 23:59:59 31/12.
    CE = 1'b1;
    do_load(23, 59, 59, 31, 12, 5);
    sp_cnt = 0;
    repeat (4) step();
    chk("t1_hours", 32'(Hours), 32'd0);
    chk("t1_day", 32'(Day), 32'd1);
    chk("t1_month", 32'(Month), 32'd1);
    chk("t1_year", 32'(Year), 32'd6);
    chk("t1_sec_pulses", 32'(sp_cnt), 32'd1);

    // February in leap, century and 400-year cases.
    do_load(23, 59, 59, 28, 2, 24);
    repeat (4) step();
    chk("t2_y24_day", 32'(Day), 32'd29);
    do_load(23, 59, 59, 28, 2, 100);
    repeat (4) step();
    chk("t2_y100_day", 32'(Day), 32'd1);
    chk("t2_y100_month", 32'(Month), 32'd3);
    do_load(23, 59, 59, 28, 2, 0);
    repeat (4) step();
    chk("t2_y0_day", 32'(Day), 32'd29);

    // Rejected loads.
    do_load(10, 20, 30, 31, 4, 5);
    chk("t3_day31_err", 32'(LOAD_ERR), 32'd1);
    step();
    do_load(24, 0, 0, 1, 1, 0);
    chk("t3_hours24_err", 32'(LOAD_ERR), 32'd1);
    chk("t3_hours24_day", 32'(Day), 32'd29);

    // Alarm by tick, not by load.
    ALARM_EN = 1'b1; A_HOURS = 5'd7; A_MINS = 6'd30;
    do_load(7, 29, 58, 10, 6, 20);
    al_cnt = 0;
    repeat (10) step();
    chk("t4_alarm_count", 32'(al_cnt), 32'd1);
    al_cnt = 0;
    do_load(7, 30, 0, 10, 6, 20);
    repeat (3) step();
    chk("t4_reload_no_alarm", 32'(al_cnt), 32'd0);
    ALARM_EN = 1'b0;

    // 12-hour decode.
    do_load(0, 10, 0, 1, 1, 0);
    chk("t5_h0_h12", 32'(Hours12), 32'd12);
    chk("t5_h0_pm", 32'(PM), 32'd0);
    do_load(13, 10, 0, 1, 1, 0);
    chk("t5_h13_h12", 32'(Hours12), 32'd1);
    chk("t5_h13_pm", 32'(PM), 32'd1);
    do_load(12, 10, 0, 1, 1, 0);
    chk("t5_h12_h12", 32'(Hours12), 32'd12);
    chk("t5_h12_pm", 32'(PM), 32'd1);

    // Asynchronous reset mid-prescale, coincident with a load.
    do_load(5, 5, 5, 5, 5, 5);
    repeat (2) step();
    #3;
    L_HOURS = 5'd9; L_DAY = 5'd9;
    RST = 1'b1; LOAD = 1'b1;
    #1;
    m_reset();
    check_all();
    step();
    RST = 1'b0; LOAD = 1'b0;

    // Load honoured with CE low, then no advance for 100 cycles.
    CE = 1'b0;
    do_load(1, 2, 3, 4, 5, 6);
    repeat (100) step();
    chk("t6_ce_low_secs", 32'(Secs), 32'd3);
    chk("t6_ce_low_hours", 32'(Hours), 32'd1);

    // Randomized traffic biased toward carry boundaries.
    for (int i = 0; i < 2500; i++) begin
      CE = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) begin
        L_HOURS = $urandom_range(0, 1) ? 5'd23 : 5'($urandom_range(0, 25));
        L_MINS  = $urandom_range(0, 1) ? 6'd59 : 6'($urandom_range(0, 61));
        L_SECS  = 6'($urandom_range(50, 61));
        L_DAY   = $urandom_range(0, 1) ? 5'($urandom_range(28, 31)) : 5'($urandom_range(0, 31));
        L_MONTH = $urandom_range(0, 1) ? ($urandom_range(0, 1) ? 4'd2 : 4'd12) : 4'($urandom_range(0, 13));
        L_YEAR  = $urandom_range(0, 1) ? 7'(ylist[$urandom_range(0, 4)]) : 7'($urandom_range(0, 127));
        ALARM_EN = ($urandom_range(0, 3) != 0);
        A_HOURS = $urandom_range(0, 1) ? L_HOURS : 5'($urandom_range(0, 31));
        A_MINS  = $urandom_range(0, 1) ? 6'(L_MINS + 6'd1) : 6'($urandom_range(0, 63));
        LOAD = 1'b1;
      end else begin
        LOAD = 1'b0;
      end
      step();
    end
    LOAD = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
